// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if: measured square wave in, period/high-time results out.
interface clk_period_meter_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 sig_in;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] high_time;
    logic                 period_valid;
    logic                 timeout;
    modport master (output sig_in, input period, high_time, period_valid, timeout);
    modport slave (input sig_in, output period, high_time, period_valid, timeout);
endinterface

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period/high time of a slow async wave in clk_in cycles, flags loss of signal.
// Define CLK_PERIOD_METER_AVG4_EN to report the truncated average of every four periods instead.
module clk_period_meter #(
    parameter int              CNT_WIDTH = 32,
    parameter longint unsigned TIMEOUT   = 100_000_000
) (
    input logic                clk_in,
    input logic                reset,
    clk_period_meter_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT);
    typedef enum logic {WAIT_EDGE, MEASURE} state_t;
    state_t state, state_nxt;
    logic s1, s2, s3, rise, fall;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt, hi_cap, hi_cap_nxt;
    logic [CNT_WIDTH-1:0] period_q, period_nxt, high_q, high_nxt;
    logic pv_q, pv_nxt, to_q, to_nxt;
`ifdef CLK_PERIOD_METER_AVG4_EN
    logic [CNT_WIDTH+1:0] acc_p, acc_p_nxt, acc_h, acc_h_nxt, sum_p, sum_h;
    logic [1:0] sub, sub_nxt;
`endif
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;
    assign bus.period       = period_q;
    assign bus.high_time    = high_q;
    assign bus.period_valid = pv_q;
    assign bus.timeout      = to_q;
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            {s1, s2, s3} <= 3'b000;
            state        <= WAIT_EDGE;
            cnt          <= '0;
            hi_cap       <= '0;
            period_q     <= '0;
            high_q       <= '0;
            pv_q         <= 1'b0;
            to_q         <= 1'b0;
`ifdef CLK_PERIOD_METER_AVG4_EN
            acc_p        <= '0;
            acc_h        <= '0;
            sub          <= '0;
`endif
        end else begin
            {s1, s2, s3} <= {bus.sig_in, s1, s2};
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            hi_cap       <= hi_cap_nxt;
            period_q     <= period_nxt;
            high_q       <= high_nxt;
            pv_q         <= pv_nxt;
            to_q         <= to_nxt;
`ifdef CLK_PERIOD_METER_AVG4_EN
            acc_p        <= acc_p_nxt;
            acc_h        <= acc_h_nxt;
            sub          <= sub_nxt;
`endif
        end
    end
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hi_cap_nxt = fall ? cnt : hi_cap;
        period_nxt = period_q;
        high_nxt   = high_q;
        pv_nxt     = 1'b0;
        to_nxt     = to_q;
`ifdef CLK_PERIOD_METER_AVG4_EN
        acc_p_nxt  = acc_p;
        acc_h_nxt  = acc_h;
        sub_nxt    = sub;
        sum_p      = acc_p + {2'b00, cnt};
        sum_h      = acc_h + {2'b00, hi_cap};
`endif
        if (state == WAIT_EDGE) begin
            cnt_nxt = '0;
            if (rise) begin
                state_nxt = MEASURE;
                cnt_nxt   = CNT_WIDTH'(1);
                to_nxt    = 1'b0;
            end
        end else if (rise) begin
            cnt_nxt = CNT_WIDTH'(1);
`ifdef CLK_PERIOD_METER_AVG4_EN
            sub_nxt = sub + 2'd1;
            if (sub == 2'd3) begin
                period_nxt = sum_p[CNT_WIDTH+1:2];
                high_nxt   = sum_h[CNT_WIDTH+1:2];
                pv_nxt     = 1'b1;
                acc_p_nxt  = '0;
                acc_h_nxt  = '0;
            end else begin
                acc_p_nxt  = sum_p;
                acc_h_nxt  = sum_h;
            end
`else
            period_nxt = cnt;
            high_nxt   = hi_cap;
            pv_nxt     = 1'b1;
`endif
        end else if (cnt == TMO) begin
            // A rise in the same cycle takes the branch above, so P == TIMEOUT stays valid
            state_nxt = WAIT_EDGE;
            cnt_nxt   = '0;
            to_nxt    = 1'b1;
`ifdef CLK_PERIOD_METER_AVG4_EN
            acc_p_nxt = '0;
            acc_h_nxt = '0;
            sub_nxt   = '0;
`endif
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end
endmodule
